// File: rtl/mac_writeback_unit.sv
// ---------------------------------------------------------------------------------------------
// mac_writeback_unit
//
// Four-lane signed multiply-accumulate stage followed by a serialising writeback FSM.
// Each lane accumulates sign-extended w*x products. A capture strobe snapshots the four sums
// and their destination addresses. The unit then issues four consecutive single-port writes
// into the output buffer.
//
// Optional build macro: MAC_WB_SATURATE_EN
//   defined   -> written data is the accumulator saturated to the signed OUT_W range
//   undefined -> written data is the low OUT_W bits of the accumulator (two's-complement wrap)
//   The accumulators wrap modulo 2^ACC_W in both builds.
//
// Ports
//   clk                 rising-edge clock
//   rst_n               asynchronous active-low reset
//   clear               zero all four accumulators (wins over in_valid)
//   in_valid            w/x data valid on all lanes this cycle
//   w_data_1..4         signed weight per lane
//   x_data_1..4         signed input per lane
//   valid               capture strobe, honoured only when the writeback engine is idle
//   out_1..4_address    destination address per lane
//   wr_en               output buffer write enable
//   wr_addr             output buffer write address
//   wr_data             output buffer write data
//   busy                writeback in progress (high with each of the four writes)
//   done                one-cycle pulse on the last write of a group
//   overflow            sticky: a capture strobe arrived while the engine was busy
//
// Assumes ACC_W >= 2*DATA_W and ACC_W >= OUT_W.
// ---------------------------------------------------------------------------------------------
module mac_writeback_unit #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 20,
    parameter int unsigned OUT_W  = 16,
    parameter int unsigned ADDR_W = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] w_data_1,
    input  logic signed [DATA_W-1:0] w_data_2,
    input  logic signed [DATA_W-1:0] w_data_3,
    input  logic signed [DATA_W-1:0] w_data_4,
    input  logic signed [DATA_W-1:0] x_data_1,
    input  logic signed [DATA_W-1:0] x_data_2,
    input  logic signed [DATA_W-1:0] x_data_3,
    input  logic signed [DATA_W-1:0] x_data_4,
    input  logic                     valid,
    input  logic        [ADDR_W-1:0] out_1_address,
    input  logic        [ADDR_W-1:0] out_2_address,
    input  logic        [ADDR_W-1:0] out_3_address,
    input  logic        [ADDR_W-1:0] out_4_address,
    output logic                     wr_en,
    output logic        [ADDR_W-1:0] wr_addr,
    output logic        [OUT_W-1:0]  wr_data,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow
);

    localparam int unsigned LANES  = 4;
    localparam int unsigned PROD_W = 2 * DATA_W;

    typedef enum logic [2:0] {
        StIdle,
        StWr1,
        StWr2,
        StWr3,
        StWr4
    } state_t;

    state_t state;

    logic signed [DATA_W-1:0] w_lane    [LANES];
    logic signed [DATA_W-1:0] x_lane    [LANES];
    logic        [ADDR_W-1:0] addr_in   [LANES];
    logic signed [PROD_W-1:0] prod      [LANES];
    logic signed [ACC_W-1:0]  prod_ext  [LANES];
    logic signed [ACC_W-1:0]  acc       [LANES];
    logic signed [ACC_W-1:0]  hold      [LANES];
    logic        [ADDR_W-1:0] addr_hold [LANES];

    assign w_lane[0]  = w_data_1;
    assign w_lane[1]  = w_data_2;
    assign w_lane[2]  = w_data_3;
    assign w_lane[3]  = w_data_4;
    assign x_lane[0]  = x_data_1;
    assign x_lane[1]  = x_data_2;
    assign x_lane[2]  = x_data_3;
    assign x_lane[3]  = x_data_4;
    assign addr_in[0] = out_1_address;
    assign addr_in[1] = out_2_address;
    assign addr_in[2] = out_3_address;
    assign addr_in[3] = out_4_address;

    // Output formatting of a captured accumulator value.
    function automatic logic [OUT_W-1:0] fmt(input logic signed [ACC_W-1:0] v);
`ifdef MAC_WB_SATURATE_EN
        // In range exactly when every bit from the OUT_W sign position upward agrees.
        if ((&v[ACC_W-1:OUT_W-1]) || !(|v[ACC_W-1:OUT_W-1])) begin
            return OUT_W'(v);
        end else if (v[ACC_W-1]) begin
            return {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            return {1'b0, {(OUT_W-1){1'b1}}};
        end
`else
        return OUT_W'(v);
`endif
    endfunction

    // Full-width signed product, then sign-extended to the accumulator width.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            prod[k]     = PROD_W'(w_lane[k]) * PROD_W'(x_lane[k]);
            prod_ext[k] = ACC_W'(prod[k]);
        end
    end

    // Accumulators run independently of the writeback engine.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < LANES; k++) begin
                acc[k] <= '0;
            end
        end else if (clear) begin
            for (int k = 0; k < LANES; k++) begin
                acc[k] <= '0;
            end
        end else if (in_valid) begin
            for (int k = 0; k < LANES; k++) begin
                acc[k] <= acc[k] + prod_ext[k];
            end
        end
    end

    // Writeback engine. Each WRk state launches the registered write for lane k, so the write
    // is visible in the cycle after the state is occupied. busy follows wr_en exactly; the
    // cycle carrying the last write (state already back in StIdle) still counts as busy, so a
    // capture strobe there is dropped rather than accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= StIdle;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
            for (int k = 0; k < LANES; k++) begin
                hold[k]      <= '0;
                addr_hold[k] <= '0;
            end
        end else begin
            done <= 1'b0;
            if (valid && ((state != StIdle) || busy)) begin
                overflow <= 1'b1;
            end
            unique case (state)
                StIdle: begin
                    wr_en <= 1'b0;
                    busy  <= 1'b0;
                    if (valid && !busy) begin
                        for (int k = 0; k < LANES; k++) begin
                            hold[k]      <= acc[k];
                            addr_hold[k] <= addr_in[k];
                        end
                        state <= StWr1;
                    end
                end
                StWr1: begin
                    wr_en   <= 1'b1;
                    busy    <= 1'b1;
                    wr_addr <= addr_hold[0];
                    wr_data <= fmt(hold[0]);
                    state   <= StWr2;
                end
                StWr2: begin
                    wr_en   <= 1'b1;
                    busy    <= 1'b1;
                    wr_addr <= addr_hold[1];
                    wr_data <= fmt(hold[1]);
                    state   <= StWr3;
                end
                StWr3: begin
                    wr_en   <= 1'b1;
                    busy    <= 1'b1;
                    wr_addr <= addr_hold[2];
                    wr_data <= fmt(hold[2]);
                    state   <= StWr4;
                end
                StWr4: begin
                    wr_en   <= 1'b1;
                    busy    <= 1'b1;
                    done    <= 1'b1;
                    wr_addr <= addr_hold[3];
                    wr_data <= fmt(hold[3]);
                    state   <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_writeback_unit.sv
// ---------------------------------------------------------------------------------------------
// tb_mac_writeback_unit
//
// Self-checking bench. Two instances share the lane inputs: dut_a uses the default widths
// (ACC_W=20), dut_b uses ACC_W=24 for the large-sum formatting cases. Expected writes are
// pushed to a per-instance queue when a capture is driven and popped by a monitor on every
// write. Formatting expectations follow MAC_WB_SATURATE_EN when it is defined.
// ---------------------------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mac_writeback_unit;

    localparam int DATA_W = 8;
    localparam int OUT_W  = 16;
    localparam int ADDR_W = 3;
    localparam int ACC_A  = 20;
    localparam int ACC_B  = 24;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [OUT_W-1:0]  data;
        logic              last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic clear = 1'b0;
    logic in_valid = 1'b0;
    logic valid = 1'b0;
    logic valid_b = 1'b0;
    logic signed [DATA_W-1:0] w [4];
    logic signed [DATA_W-1:0] x [4];
    logic [ADDR_W-1:0] a [4];

    logic              wr_en_a, busy_a, done_a, overflow_a;
    logic [ADDR_W-1:0] wr_addr_a;
    logic [OUT_W-1:0]  wr_data_a;
    logic              wr_en_b, busy_b, done_b, overflow_b;
    logic [ADDR_W-1:0] wr_addr_b;
    logic [OUT_W-1:0]  wr_data_b;

    exp_t   sb_a[$];
    exp_t   sb_b[$];
    exp_t   e_a;
    exp_t   e_b;
    longint model_a [4];
    longint model_b [4];
    int     errors = 0;
    int     checks = 0;

    always #5 clk = ~clk;

    mac_writeback_unit #(
        .DATA_W(DATA_W), .ACC_W(ACC_A), .OUT_W(OUT_W), .ADDR_W(ADDR_W)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
        .w_data_1(w[0]), .w_data_2(w[1]), .w_data_3(w[2]), .w_data_4(w[3]),
        .x_data_1(x[0]), .x_data_2(x[1]), .x_data_3(x[2]), .x_data_4(x[3]),
        .valid(valid),
        .out_1_address(a[0]), .out_2_address(a[1]), .out_3_address(a[2]), .out_4_address(a[3]),
        .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
        .busy(busy_a), .done(done_a), .overflow(overflow_a)
    );

    mac_writeback_unit #(
        .DATA_W(DATA_W), .ACC_W(ACC_B), .OUT_W(OUT_W), .ADDR_W(ADDR_W)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
        .w_data_1(w[0]), .w_data_2(w[1]), .w_data_3(w[2]), .w_data_4(w[3]),
        .x_data_1(x[0]), .x_data_2(x[1]), .x_data_3(x[2]), .x_data_4(x[3]),
        .valid(valid_b),
        .out_1_address(a[0]), .out_2_address(a[1]), .out_3_address(a[2]), .out_4_address(a[3]),
        .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
        .busy(busy_b), .done(done_b), .overflow(overflow_b)
    );

    // Signed wrap of v to a width-bit two's-complement value.
    function automatic longint wrap_s(input longint v, input int width);
        longint span;
        longint m;
        span = longint'(1) << width;
        m = v % span;
        if (m < 0) m += span;
        if (m >= span / 2) m -= span;
        return m;
    endfunction

    function automatic logic [OUT_W-1:0] fmt_model(input longint v);
`ifdef MAC_WB_SATURATE_EN
        if (v > 32767) return 16'h7fff;
        if (v < -32768) return 16'h8000;
        return 16'(v);
`else
        return 16'(v);
`endif
    endfunction

    function automatic exp_t mk(input int addr, input longint data, input bit last);
        return {3'(addr), 16'(data), last};
    endfunction

    // Reference accumulators.
    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 4; k++) begin
            if (!rst_n || clear) begin
                model_a[k] <= 0;
                model_b[k] <= 0;
            end else if (in_valid) begin
                model_a[k] <= wrap_s(model_a[k] + longint'(w[k]) * longint'(x[k]), ACC_A);
                model_b[k] <= wrap_s(model_b[k] + longint'(w[k]) * longint'(x[k]), ACC_B);
            end
        end
    end

    // Scoreboard monitors.
    always @(negedge clk) begin
        if (wr_en_a) begin
            checks++;
            if (sb_a.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write_a: addr=%0d data=%0d, required no write",
                         wr_addr_a, $signed(wr_data_a));
            end else begin
                e_a = sb_a.pop_front();
                if (wr_addr_a !== e_a.addr || wr_data_a !== e_a.data || done_a !== e_a.last ||
                    busy_a !== 1'b1) begin
                    errors++;
                    $display("FAIL write_a: got addr=%0d data=%0d done=%0b busy=%0b, required addr=%0d data=%0d done=%0b busy=1",
                             wr_addr_a, $signed(wr_data_a), done_a, busy_a,
                             e_a.addr, $signed(e_a.data), e_a.last);
                end
            end
        end else begin
            checks++;
            if (done_a !== 1'b0 || busy_a !== 1'b0) begin
                errors++;
                $display("FAIL idle_flags_a: done=%0b busy=%0b, required 0 0", done_a, busy_a);
            end
        end
        if (wr_en_b) begin
            checks++;
            if (sb_b.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write_b: addr=%0d data=%0d, required no write",
                         wr_addr_b, $signed(wr_data_b));
            end else begin
                e_b = sb_b.pop_front();
                if (wr_addr_b !== e_b.addr || wr_data_b !== e_b.data || done_b !== e_b.last ||
                    busy_b !== 1'b1) begin
                    errors++;
                    $display("FAIL write_b: got addr=%0d data=%0d done=%0b busy=%0b, required addr=%0d data=%0d done=%0b busy=1",
                             wr_addr_b, $signed(wr_data_b), done_b, busy_b,
                             e_b.addr, $signed(e_b.data), e_b.last);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int a0, input int a1, input int a2, input int a3);
        a[0] = 3'(a0);
        a[1] = 3'(a1);
        a[2] = 3'(a2);
        a[3] = 3'(a3);
    endtask

    // Waits (bounded) until the queue is drained and the engine is idle; counts busy cycles.
    task automatic wait_drain(input bit use_b, output int bc);
        bc = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (use_b ? busy_b : busy_a) bc++;
            if (!use_b && sb_a.size() == 0 && !busy_a && !wr_en_a) break;
            if (use_b && sb_b.size() == 0 && !busy_b && !wr_en_b) break;
        end
        tick();
    endtask

    task automatic test_reset();
        #12;
        checks += 6;
        if (wr_en_a !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b, required 0", wr_en_a); end
        if (wr_addr_a !== '0) begin errors++; $display("FAIL reset_wr_addr: got %0d, required 0", wr_addr_a); end
        if (wr_data_a !== '0) begin errors++; $display("FAIL reset_wr_data: got %0d, required 0", wr_data_a); end
        if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy_a); end
        if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, required 0", done_a); end
        if (overflow_a !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b, required 0", overflow_a); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_row();
        int bc;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        in_valid = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            w[0] = 8'(i);
            x[0] = 8'(1);
            for (int k = 1; k < 4; k++) begin
                w[k] = 8'(2);
                x[k] = 8'(-3);
            end
            tick();
        end
        in_valid = 1'b0;
        set_addr(0, 1, 2, 3);
        sb_a.push_back(mk(0, 36, 1'b0));
        sb_a.push_back(mk(1, -48, 1'b0));
        sb_a.push_back(mk(2, -48, 1'b0));
        sb_a.push_back(mk(3, -48, 1'b1));
        valid = 1'b1;
        tick();
        valid = 1'b0;
        wait_drain(1'b0, bc);
        checks += 3;
        if (sb_a.size() != 0) begin errors++; $display("FAIL basic_drain: pending=%0d, required 0", sb_a.size()); end
        if (bc != 4) begin errors++; $display("FAIL basic_busy_cycles: got %0d, required 4", bc); end
        if (overflow_a !== 1'b0) begin errors++; $display("FAIL basic_overflow: got %b, required 0", overflow_a); end
    endtask

    task automatic test_edge_coincidence();
        int bc;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin w[k] = 8'(2); x[k] = 8'(5); end
        tick();
        // Capture and accumulate on the same edge: capture sees 10, acc moves to 35.
        for (int k = 0; k < 4; k++) begin w[k] = 8'(5); x[k] = 8'(5); end
        set_addr(4, 5, 6, 7);
        for (int k = 0; k < 4; k++) sb_a.push_back(mk(4 + k, 10, k == 3));
        valid = 1'b1;
        tick();
        valid = 1'b0;
        in_valid = 1'b0;
        wait_drain(1'b0, bc);
        set_addr(0, 1, 2, 3);
        for (int k = 0; k < 4; k++) sb_a.push_back(mk(k, 35, k == 3));
        valid = 1'b1;
        tick();
        valid = 1'b0;
        wait_drain(1'b0, bc);
        checks++;
        if (sb_a.size() != 0) begin errors++; $display("FAIL coincide_capture: pending=%0d, required 0", sb_a.size()); end
        // Clear wins over a simultaneous product.
        clear = 1'b1;
        in_valid = 1'b1;
        tick();
        clear = 1'b0;
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) sb_a.push_back(mk(k, 0, k == 3));
        valid = 1'b1;
        tick();
        valid = 1'b0;
        wait_drain(1'b0, bc);
        checks++;
        if (sb_a.size() != 0) begin errors++; $display("FAIL coincide_clear: pending=%0d, required 0", sb_a.size()); end
    endtask

    task automatic test_back_to_back();
        int bc;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin w[k] = 8'(k + 1); x[k] = 8'(3); end
        tick();
        in_valid = 1'b0;
        set_addr(0, 1, 2, 3);
        for (int k = 0; k < 4; k++) sb_a.push_back(mk(k, 3 * (k + 1), k == 3));
        valid = 1'b1;
        tick();
        valid = 1'b0;
        tick();
        tick();
        // Now in the cycle showing the second write: this strobe must be dropped.
        set_addr(7, 7, 7, 7);
        valid = 1'b1;
        tick();
        valid = 1'b0;
        wait_drain(1'b0, bc);
        checks += 2;
        if (sb_a.size() != 0) begin errors++; $display("FAIL b2b_first_group: pending=%0d, required 0", sb_a.size()); end
        if (overflow_a !== 1'b1) begin errors++; $display("FAIL b2b_overflow_set: got %b, required 1", overflow_a); end
        set_addr(4, 5, 6, 7);
        for (int k = 0; k < 4; k++) sb_a.push_back(mk(4 + k, 3 * (k + 1), k == 3));
        valid = 1'b1;
        tick();
        valid = 1'b0;
        wait_drain(1'b0, bc);
        checks += 3;
        if (sb_a.size() != 0) begin errors++; $display("FAIL b2b_second_group: pending=%0d, required 0", sb_a.size()); end
        if (bc != 4) begin errors++; $display("FAIL b2b_busy_cycles: got %0d, required 4", bc); end
        if (overflow_a !== 1'b1) begin errors++; $display("FAIL b2b_overflow_sticky: got %b, required 1", overflow_a); end
    endtask

    task automatic test_async_reset();
        int bc;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin w[k] = 8'(1); x[k] = 8'(7); end
        tick();
        in_valid = 1'b0;
        set_addr(0, 1, 2, 3);
        for (int k = 0; k < 3; k++) sb_a.push_back(mk(k, 7, 1'b0));
        valid = 1'b1;
        tick();
        valid = 1'b0;
        tick();
        tick();
        tick();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks += 5;
        if (wr_en_a !== 1'b0) begin errors++; $display("FAIL areset_wr_en: got %b, required 0", wr_en_a); end
        if (busy_a !== 1'b0) begin errors++; $display("FAIL areset_busy: got %b, required 0", busy_a); end
        if (done_a !== 1'b0) begin errors++; $display("FAIL areset_done: got %b, required 0", done_a); end
        if (overflow_a !== 1'b0) begin errors++; $display("FAIL areset_overflow: got %b, required 0", overflow_a); end
        if (sb_a.size() != 0) begin errors++; $display("FAIL areset_wr3_seen: pending=%0d, required 0", sb_a.size()); end
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) sb_a.push_back(mk(k, 0, k == 3));
        valid = 1'b1;
        tick();
        valid = 1'b0;
        wait_drain(1'b0, bc);
        checks += 2;
        if (sb_a.size() != 0) begin errors++; $display("FAIL areset_recapture: pending=%0d, required 0", sb_a.size()); end
        if (overflow_a !== 1'b0) begin errors++; $display("FAIL areset_overflow_after: got %b, required 0", overflow_a); end
    endtask

    task automatic test_saturation();
        int bc;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        w[0] = 8'(127);  x[0] = 8'(127);
        w[1] = 8'(127);  x[1] = 8'(127);
        w[2] = 8'(-128); x[2] = 8'(127);
        w[3] = 8'(3);    x[3] = 8'(-1);
        in_valid = 1'b1;
        repeat (300) tick();
        in_valid = 1'b0;
        set_addr(0, 1, 2, 3);
        for (int k = 0; k < 4; k++) sb_b.push_back(mk(k, longint'(fmt_model(model_b[k])), k == 3));
        valid_b = 1'b1;
        tick();
        valid_b = 1'b0;
        wait_drain(1'b1, bc);
        checks += 2;
        if (sb_b.size() != 0) begin errors++; $display("FAIL sat_group: pending=%0d, required 0", sb_b.size()); end
        if (bc != 4) begin errors++; $display("FAIL sat_busy_cycles: got %0d, required 4", bc); end
    endtask

    task automatic test_wrap();
        int bc;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int k = 0; k < 4; k++) begin w[k] = 8'(127); x[k] = 8'(127); end
        in_valid = 1'b1;
        repeat (32) tick();
        // Lane 1 lands exactly one past 2^19-1 and wraps to -2^19.
        w[0] = 8'(80);   x[0] = 8'(102);
        w[1] = 8'(80);   x[1] = 8'(101);
        w[2] = 8'(0);    x[2] = 8'(5);
        w[3] = 8'(-128); x[3] = 8'(127);
        tick();
        in_valid = 1'b0;
        set_addr(3, 2, 1, 0);
        for (int k = 0; k < 4; k++) sb_a.push_back(mk(3 - k, longint'(fmt_model(model_a[k])), k == 3));
        valid = 1'b1;
        tick();
        valid = 1'b0;
        wait_drain(1'b0, bc);
        checks++;
        if (sb_a.size() != 0) begin errors++; $display("FAIL wrap_group: pending=%0d, required 0", sb_a.size()); end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            w[k] = '0;
            x[k] = '0;
            a[k] = '0;
        end
        test_reset();
        test_basic_row();
        test_edge_coincidence();
        test_back_to_back();
        test_async_reset();
        test_saturation();
        test_wrap();
        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mac_writeback_unit.md
Name: mac_writeback_unit

Overview:
- Four-lane signed multiply-accumulate stage that sits directly downstream of the address generator and its W/X buffers.
- Each lane accumulates w*x products for one output row. On the upstream valid strobe, the four sums and their output addresses are captured.
- The captured results are serialized as four single-port writes into the output buffer.

Parameters:
- DATA_W, 8: signed width of each w/x operand
- ACC_W, 20: signed accumulator width
- OUT_W, 16: signed width written to the output buffer
- ADDR_W, 3: output buffer address width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  zero all four accumulators
- in_valid  in  1  w/x data on all lanes valid this cycle (buffer read data, already latency-aligned by top level)
- w_data_1..w_data_4  in  DATA_W each  signed weight per lane
- x_data_1..x_data_4  in  DATA_W each  signed input per lane
- valid  in  1  capture strobe: snapshot accumulators and out addresses
- out_1_address..out_4_address  in  ADDR_W each  destination address per lane
- wr_en  out  1  output buffer write enable
- wr_addr  out  ADDR_W  output buffer write address
- wr_data  out  OUT_W  output buffer write data
- busy  out  1  writeback in progress
- done  out  1  one-cycle pulse on the last write of a group
- overflow  out  1  sticky: a capture was dropped while busy

Behaviour:
- Reset: asynchronous on rst_n low. All of the following go to 0: accumulators, holding registers, wr_en, wr_addr, wr_data, busy, done, overflow. FSM returns to IDLE. Pending writes are discarded, including when reset hits mid-writeback.
- Accumulate, per lane, each clk:
  - clear=1: acc <= 0. Clear has priority; a product arriving in the same cycle is discarded.
  - clear=0 and in_valid=1: acc <= acc + sext(w*x). Full 2*DATA_W signed product, sign-extended. Wraps modulo 2^ACC_W.
  - Otherwise acc holds.
- Capture, when valid=1 and FSM is in IDLE:
  - hold_k <= acc_k, the registered value before any same-edge update.
  - addr_k <= out_k_address.
  - busy <= 1; FSM goes to WR1.
  - valid is sampled in IDLE only.
- FSM states: IDLE, WR1, WR2, WR3, WR4.
  - In WRk: wr_en=1, wr_addr=addr_k, wr_data=fmt(hold_k).
  - Transitions: WR1 -> WR2 -> WR3 -> WR4 -> IDLE, one cycle each.
  - In WR4: done=1. On exit, busy <= 0 and wr_en <= 0.
  - All write outputs are registered.
- Timing: valid sampled at edge k gives wr_en high for the cycles following edges k+1..k+4. busy is high over the same cycles. done is high with the WR4 write. The unit can accept a new valid in the cycle after WR4.
- Valid while busy (any WR state): capture ignored, overflow <= 1 (sticky until reset). The in-flight group completes unaffected.
- clear/in_valid during writeback: allowed. Accumulation continues independently of the FSM and does not disturb hold registers.
- Output formatting, fmt(): see Optional Feature. Default is truncation to the low OUT_W bits.
- Outside WR states: wr_en=0. wr_addr and wr_data hold their last values.

Optional Feature:
- Macro: MAC_WB_SATURATE_EN
- Defined: fmt() saturates the signed ACC_W value to the signed OUT_W range [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Undefined: fmt() takes acc[OUT_W-1:0] (two's-complement wrap).
- Accumulator arithmetic wraps in both builds.

Test Plan:
- Basic row: clear 1 cycle, then 8 in_valid cycles with lane1 w=1..8, x=1 and lanes2-4 w=2, x=-3. Pulse valid with addresses 0,1,2,3. Expect writes (0,36), (1,-48), (2,-48), (3,-48) on consecutive cycles; done on the 4th; busy for 4 cycles.
- Edge-coincidence: valid together with in_valid (w=5, x=5) after acc=10. Expect captured 10, acc becomes 35. Separately, clear together with in_valid: acc=0.
- Back-to-back: valid again in the WR2 cycle. Expect no second group and overflow=1 held. Then valid in IDLE gives a normal 4-write group, with overflow still 1.
- Async reset: assert rst_n low during WR3. Expect wr_en, busy, done and overflow at 0 immediately, with no WR4 write. After release, the accumulator reads 0 on the next capture.
- Saturation, OUT_W=16: accumulate 300 cycles of w=127, x=127 (sum 4838700, fits ACC_W=20? no: test with ACC_W=24). Without MAC_WB_SATURATE_EN, wr_data = 4838700 mod 2^16 reinterpreted signed (=-10964). With it, wr_data = 32767. Negative case (w=-128, x=127): -32768.
- Wrap: ACC_W=20, sum exceeding 2^19-1 by 1 reads back -2^19 truncated per fmt.
